// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Issues one IITB-RISC arithmetic instruction to the ALU, owns
//               the C/Z flags and produces a single register-file write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [1:0]        alu_sel,
    output logic [DATA_W-1:0] alu_arg1,
    output logic [DATA_W-1:0] alu_arg2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              c_flag,
    output logic              z_flag,
    output logic              done,
    output logic              illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_ADI  = 4'b0001;
    localparam logic [3:0] c_OP_NAND = 4'b0010;

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_instr;
    logic              r_exec;
    logic              r_illegal;
    logic [REG_AW-1:0] r_dest;
    logic [1:0]        r_alu_sel;
    logic [DATA_W-1:0] r_arg1;
    logic [DATA_W-1:0] r_arg2;
    logic [REG_AW-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_c;
    logic              r_z;

    logic [3:0]        w_op;
    logic [2:0]        w_ra;
    logic [2:0]        w_rb;
    logic [2:0]        w_rc;
    logic [1:0]        w_cz;
    logic [5:0]        w_imm6;
    logic              w_legal;
    logic              w_cond;
    logic [DATA_W-1:0] w_imm_sext;

    assign w_op       = r_instr[15:12];
    assign w_ra       = r_instr[11:9];
    assign w_rb       = r_instr[8:6];
    assign w_rc       = r_instr[5:3];
    assign w_cz       = r_instr[1:0];
    assign w_imm6     = r_instr[5:0];
    assign w_imm_sext = {{(DATA_W-6){w_imm6[5]}}, w_imm6};

    // ADI ignores CZ entirely; the register-register families treat CZ=11 as illegal
    assign w_legal = (w_op == c_OP_ADI) ||
                     (((w_op == c_OP_ADD) || (w_op == c_OP_NAND)) && (w_cz != 2'b11));
    assign w_cond  = (w_op == c_OP_ADI) || (w_cz == 2'b00) ||
                     ((w_cz == 2'b10) && r_c) || ((w_cz == 2'b01) && r_z);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (instr_valid) w_next = S_READ;
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr   <= '0;
            r_exec    <= 1'b0;
            r_illegal <= 1'b0;
            r_dest    <= '0;
            r_alu_sel <= 2'b00;
            r_arg1    <= '0;
            r_arg2    <= '0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_c       <= 1'b0;
            r_z       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) r_instr <= instr;
                end
                S_READ: begin
                    // Operands are captured straight into the ALU drive registers so
                    // they stay stable for the whole EXEC cycle.
                    r_exec    <= w_legal && w_cond;
                    r_illegal <= !w_legal;
                    r_alu_sel <= (w_op == c_OP_NAND) ? 2'b01 : 2'b00;
                    r_arg1    <= rf_rdata1;
                    r_arg2    <= (w_op == c_OP_ADI) ? w_imm_sext : rf_rdata2;
                    r_dest    <= (w_op == c_OP_ADI) ? w_rb : w_rc;
                end
                S_EXEC: begin
                    if (r_exec) begin
                        r_waddr <= r_dest;
                        r_wdata <= alu_result;
                        r_z     <= alu_zero;
                        if (w_op != c_OP_NAND) r_c <= alu_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_ready = (r_state == S_IDLE);
    assign rf_raddr1   = w_ra[REG_AW-1:0];
    assign rf_raddr2   = w_rb[REG_AW-1:0];
    assign alu_sel     = r_alu_sel;
    assign alu_arg1    = r_arg1;
    assign alu_arg2    = r_arg2;
    assign done        = (r_state == S_WB);
    assign rf_we       = done && r_exec;
    assign illegal     = done && r_illegal;
    assign rf_waddr    = r_waddr;
    assign rf_wdata    = r_wdata;
    assign c_flag      = r_c;
    assign z_flag      = r_z;

endmodule

`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the 16-bit ALU interface. Accepts one decoded-format IITB-RISC arithmetic instruction (ADD/ADC/ADZ, ADI, NDU/NDC/NDZ), reads operands from the register file, drives ALU sel/arg1/arg2, and captures result/carry/zero. Owns the architectural C and Z flags, evaluates conditional execution, and issues a one-cycle register-file write. Multi-cycle controller between decode and the register file/ALU pair.

Parameters:
DATA_W, 16, datapath width; ALU interface fixed at 16
REG_AW, 3, register address width (8 GPRs)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept (IDLE only)
instr  in  16  [15:12] opcode, [11:9] RA, [8:6] RB, [5:3] RC, [5:0] Imm6, [1:0] CZ
rf_raddr1  out  REG_AW  operand-1 read address (RA)
rf_raddr2  out  REG_AW  operand-2 read address (RB)
rf_rdata1  in  16  combinational read data for rf_raddr1
rf_rdata2  in  16  combinational read data for rf_raddr2
alu_sel  out  2  00 add, 01 bitwise NAND
alu_arg1  out  16  ALU operand 1
alu_arg2  out  16  ALU operand 2
alu_result  in  16  combinational ALU result
alu_carry  in  1  carry-out of 16-bit add
alu_zero  in  1  result == 0
rf_we  out  1  one-cycle write strobe
rf_waddr  out  REG_AW  write address
rf_wdata  out  16  write data
c_flag  out  1  architectural carry flag
z_flag  out  1  architectural zero flag
done  out  1  one-cycle completion pulse
illegal  out  1  valid with done: opcode unsupported, no side effects

Behaviour:
- Reset (async, rst_n=0): state IDLE; c_flag, z_flag, rf_we, done, illegal = 0; alu_sel = 00; alu_arg1/arg2, rf_waddr, rf_wdata = 0; instr_ready = 1 after release. Reset mid-instruction aborts: no write, flags cleared.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE. instr_ready = 1 only in IDLE; accept on instr_valid & instr_ready, latch instr.
- READ: rf_raddr1=RA, rf_raddr2=RB; latch rf_rdata1/2. Evaluate condition from flags now: CZ=00 execute; 10 execute iff c_flag; 01 execute iff z_flag; CZ=11 illegal.
- EXEC: opcode 0000 (ADD family): sel=00, arg1=rA, arg2=rB, dest RC. 0001 (ADI): sel=00, arg1=rA, arg2=sign-extended Imm6, dest RB, CZ ignored (always execute). 0010 (NAND family): sel=01, arg1=rA, arg2=rB, dest RC. Latch alu_result/alu_carry/alu_zero. ALU args/sel held stable throughout EXEC.
- Flag update at end of EXEC, only if executed: ADD/ADC/ADZ/ADI update C and Z; NAND family updates Z only, C preserved. Skipped conditional: no flag change.
- WB: done=1 for exactly one cycle. If executed and legal: rf_we=1, rf_waddr=dest, rf_wdata=latched result. Otherwise rf_we=0.
- Other opcodes or CZ=11: illegal=1 with done, no write, flags unchanged.
- Latency: accept at cycle N, rf_we/done at N+3; throughput 1 instr / 4 cycles; next accept at N+4.
- Dest may equal source; read at READ precedes write at WB, so no hazard inside the block.
- instr_valid while busy is ignored, not latched.

Test Plan:
- Reset, then ADD R1=0x0003 + R2=0x0004 -> R3 -> rf_we at N+3, waddr=3, wdata=0x0007, C=0, Z=0, done=1 one cycle.
- ADD 0xFFFF + 0x0001 -> wdata=0x0000, C=1, Z=1; then NDU 0xFFFF NAND 0xFFFF -> 0x0000, Z=1, C stays 1.
- ADC with C=0 -> done=1, rf_we=0, flags unchanged; repeat with C=1 -> write occurs, flags updated.
- ADI RA=0x0005, Imm6=0x3F (-1) -> RB=0x0004, C=1, Z=0; Imm6=0x20 -> arg2=0xFFE0.
- Opcode 0101 and ADD with CZ=11 -> illegal=1, done=1, rf_we=0, flags unchanged; instr_ready high again at N+4.
- rst_n low during EXEC of ADD -> no rf_we, no done, C=Z=0, instr_ready=1 after release.
